// File: rtl/ahb_arbiter.sv
// Round-robin AHB bus arbiter: one-hot HGRANT, registered HMASTER/HMASTLOCK,
// never breaks fixed-length bursts or locked sequences.
module ahb_arbiter #(
    parameter int NUM_MASTERS    = 4,
    parameter int DEFAULT_MASTER = 0
) (
    input  logic                           Hclk,
    input  logic                           Hrst,
    input  logic [NUM_MASTERS-1:0]         HBUSREQ,
    input  logic [NUM_MASTERS-1:0]         HLOCK,
    input  logic [1:0]                     HTRANS,
    input  logic [2:0]                     HBURST,
    input  logic                           HREADY,
    output logic [NUM_MASTERS-1:0]         HGRANT,
    output logic [$clog2(NUM_MASTERS)-1:0] HMASTER,
    output logic                           HMASTLOCK
);

    localparam int                 IDX_W      = $clog2(NUM_MASTERS);
    localparam logic [IDX_W-1:0]   DEF_IDX    = IDX_W'(DEFAULT_MASTER);
    localparam logic [IDX_W:0]     NUM_EXT    = (IDX_W+1)'(NUM_MASTERS);
    localparam logic [1:0]         TR_IDLE    = 2'b00;
    localparam logic [1:0]         TR_NONSEQ  = 2'b10;
    localparam logic [1:0]         TR_SEQ     = 2'b11;
    localparam logic [2:0]         BURST_INCR = 3'b001;

    logic [NUM_MASTERS-1:0] grant_r;
    logic [IDX_W-1:0]       grant_idx_r;
    logic [IDX_W-1:0]       last_idx_r;
    logic [4:0]             beats_left_r;
    logic                   undef_incr_r;
    logic [IDX_W-1:0]       hmaster_r;
    logic                   hmastlock_r;

    logic [4:0]             after_s;
    logic                   undef_now_s;
    logic                   locked_s;
    logic                   owner_req_s;
    logic                   arb_s;
    logic                   found_s;
    logic [IDX_W-1:0]       scan_idx_s;
    logic [IDX_W:0]         cand_s;

    // Beats remaining after the first beat of a burst; undefined INCR counts as 0.
    function automatic logic [4:0] burst_len_m1(input logic [2:0] burst);
        logic [4:0] len_m1;
        case (burst)
            3'b010, 3'b011: len_m1 = 5'd3;
            3'b100, 3'b101: len_m1 = 5'd7;
            3'b110, 3'b111: len_m1 = 5'd15;
            default:        len_m1 = 5'd0;
        endcase
        return len_m1;
    endfunction

    function automatic logic [NUM_MASTERS-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_MASTERS-1:0] vec;
        vec      = {NUM_MASTERS{1'b0}};
        vec[idx] = 1'b1;
        return vec;
    endfunction

    assign locked_s    = HLOCK[grant_idx_r];
    assign owner_req_s = HBUSREQ[grant_idx_r];

    // Beats left after the beat currently on the bus, and whether it is an undefined INCR.
    always_comb begin
        after_s     = beats_left_r;
        undef_now_s = 1'b0;
        case (HTRANS)
            TR_NONSEQ: begin
                after_s     = burst_len_m1(HBURST);
                undef_now_s = (HBURST == BURST_INCR);
            end
            TR_SEQ: begin
                after_s     = (beats_left_r == 5'd0) ? 5'd0 : beats_left_r - 5'd1;
                undef_now_s = undef_incr_r;
            end
            default: begin
                after_s     = beats_left_r;
                undef_now_s = 1'b0;
            end
        endcase
    end

    // Fixed bursts hand over one beat early so the new owner's NONSEQ follows the last beat.
    assign arb_s = HREADY && !locked_s &&
                   ((HTRANS == TR_IDLE) ||
                    (HTRANS[1] && (undef_now_s ? !owner_req_s : (after_s <= 5'd1))));

    // Round-robin scan starting just after the last real winner; falls back to the park master.
    always_comb begin
        found_s    = 1'b0;
        scan_idx_s = DEF_IDX;
        cand_s     = {(IDX_W+1){1'b0}};
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            cand_s     = {1'b0, last_idx_r} + (IDX_W+1)'(i);
            cand_s     = (cand_s >= NUM_EXT) ? cand_s - NUM_EXT : cand_s;
            scan_idx_s = (HBUSREQ[cand_s[IDX_W-1:0]] && !found_s) ? cand_s[IDX_W-1:0] : scan_idx_s;
            found_s    = found_s | HBUSREQ[cand_s[IDX_W-1:0]];
        end
    end

    // Burst tracking and address-phase ownership, both frozen by wait states.
    always_ff @(posedge Hclk) begin
        if (Hrst) begin
            beats_left_r <= 5'd0;
            undef_incr_r <= 1'b0;
            hmaster_r    <= DEF_IDX;
            hmastlock_r  <= 1'b0;
        end else if (HREADY) begin
            hmaster_r   <= grant_idx_r;
            hmastlock_r <= locked_s;
            if (HTRANS[1]) begin
                beats_left_r <= after_s;
            end
            if (HTRANS == TR_NONSEQ) begin
                undef_incr_r <= undef_now_s;
            end
        end
    end

    // Grant and round-robin pointer, updated only at arbitration points.
    always_ff @(posedge Hclk) begin
        if (Hrst) begin
            grant_idx_r <= DEF_IDX;
            grant_r     <= onehot(DEF_IDX);
            last_idx_r  <= DEF_IDX;
        end else if (arb_s) begin
            grant_idx_r <= scan_idx_s;
            grant_r     <= onehot(scan_idx_s);
            if (found_s) begin
                last_idx_r <= scan_idx_s;
            end
        end
    end

    assign HGRANT    = grant_r;
    assign HMASTER   = hmaster_r;
    assign HMASTLOCK = hmastlock_r;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Self-checking bench for ahb_arbiter: directed scenarios plus randomized traffic
// compared against a behavioural model of the arbitration rules.
module tb_ahb_arbiter;

    localparam int N   = 4;
    localparam int DEF = 0;

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] NONSEQ = 2'b10;
    localparam logic [1:0] SEQ    = 2'b11;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] busreq;
    logic [3:0] lock;
    logic [1:0] trans;
    logic [2:0] burst;
    logic       ready;
    logic [3:0] grant;
    logic [1:0] master;
    logic       mastlock;

    int checks = 0;
    int passes = 0;

    // Behavioural model state
    int m_owner, m_rr, m_beats, m_master;
    bit m_undef, m_mlock;
    int burst_len [8] = '{1, 1, 4, 4, 8, 8, 16, 16};

    always #5 clk = ~clk;

    ahb_arbiter #(.NUM_MASTERS(N), .DEFAULT_MASTER(DEF)) dut (
        .Hclk(clk), .Hrst(rst), .HBUSREQ(busreq), .HLOCK(lock),
        .HTRANS(trans), .HBURST(burst), .HREADY(ready),
        .HGRANT(grant), .HMASTER(master), .HMASTLOCK(mastlock)
    );

    task automatic model_update();
        int  after;
        int  win;
        bit  undef_now, lockd, arb;
        if (rst) begin
            m_owner = DEF; m_rr = DEF; m_beats = 0; m_undef = 0; m_master = DEF; m_mlock = 0;
        end else begin
            lockd     = lock[m_owner];
            after     = m_beats;
            undef_now = 0;
            if (trans == NONSEQ) begin
                after     = burst_len[burst] - 1;
                undef_now = (burst == 3'b001);
            end else if (trans == SEQ) begin
                after     = (m_beats > 0) ? m_beats - 1 : 0;
                undef_now = m_undef;
            end
            arb = ready && !lockd &&
                  ((trans == IDLE) || (trans[1] && (undef_now ? !busreq[m_owner] : after <= 1)));
            if (ready) begin
                m_master = m_owner;
                m_mlock  = lockd;
                if (trans[1]) m_beats = after;
                if (trans == NONSEQ) m_undef = undef_now;
            end
            if (arb) begin
                win = -1;
                for (int k = 1; k <= N; k++)
                    if (win < 0 && busreq[(m_rr + k) % N]) win = (m_rr + k) % N;
                if (win >= 0) begin
                    m_owner = win;
                    m_rr    = win;
                end else begin
                    m_owner = DEF;
                end
            end
        end
    endtask

    task automatic drive(input logic r, input logic [3:0] req, input logic [3:0] lk,
                         input logic [1:0] tr, input logic [2:0] bu, input logic rdy);
        rst = r; busreq = req; lock = lk; trans = tr; burst = bu; ready = rdy;
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic test_reset();
        drive(1'b1, 4'b1111, 4'b0000, IDLE, 3'b000, 1'b1);
        tick(); tick();
        checks++; if (grant !== 4'b0001) $display("FAIL reset_grant got %b exp %b", grant, 4'b0001); else passes++;
        checks++; if (master !== 2'd0) $display("FAIL reset_master got %0d exp 0", master); else passes++;
        checks++; if (mastlock !== 1'b0) $display("FAIL reset_mastlock got %b exp 0", mastlock); else passes++;
        drive(1'b0, 4'b1111, 4'b0000, IDLE, 3'b000, 1'b1);
        tick();
        checks++; if (grant !== 4'b0010) $display("FAIL release_grant got %b exp %b", grant, 4'b0010); else passes++;
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [1:0] exp_m [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
        drive(1'b1, 4'b1111, 4'b0000, IDLE, 3'b000, 1'b1);
        tick();
        drive(1'b0, 4'b1111, 4'b0000, IDLE, 3'b000, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (grant !== exp_g[i]) $display("FAIL rr_grant[%0d] got %b exp %b", i, grant, exp_g[i]); else passes++;
            checks++; if (master !== exp_m[i]) $display("FAIL rr_master[%0d] got %0d exp %0d", i, master, exp_m[i]); else passes++;
        end
    endtask

    // Reset, then let master 2 take ownership of an idle bus.
    task automatic own_master2();
        drive(1'b1, 4'b0000, 4'b0000, IDLE, 3'b000, 1'b1);
        tick();
        drive(1'b0, 4'b0100, 4'b0000, IDLE, 3'b000, 1'b1);
        tick(); tick();
    endtask

    task automatic test_incr4();
        own_master2();
        checks++; if (grant !== 4'b0100 || master !== 2'd2)
            $display("FAIL incr4_setup got %b/%0d exp 0100/2", grant, master); else passes++;
        drive(1'b0, 4'b0110, 4'b0000, NONSEQ, 3'b011, 1'b1);
        tick();
        checks++; if (grant !== 4'b0100) $display("FAIL incr4_beat1 got %b exp 0100", grant); else passes++;
        trans = SEQ;
        tick();
        checks++; if (grant !== 4'b0100) $display("FAIL incr4_beat2 got %b exp 0100", grant); else passes++;
        tick();
        checks++; if (grant !== 4'b0010) $display("FAIL incr4_beat3_grant got %b exp 0010", grant); else passes++;
        checks++; if (master !== 2'd2) $display("FAIL incr4_beat3_master got %0d exp 2", master); else passes++;
        busreq = 4'b0010;
        tick();
        checks++; if (master !== 2'd1) $display("FAIL incr4_beat4_master got %0d exp 1", master); else passes++;
        checks++; if (grant !== 4'b0010) $display("FAIL incr4_beat4_grant got %b exp 0010", grant); else passes++;
        trans = IDLE;
        tick();
    endtask

    task automatic test_wait_states();
        own_master2();
        drive(1'b0, 4'b0110, 4'b0000, NONSEQ, 3'b011, 1'b1);
        tick();
        drive(1'b0, 4'b0110, 4'b0000, SEQ, 3'b011, 1'b0);
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (grant !== 4'b0100) $display("FAIL wait_grant[%0d] got %b exp 0100", i, grant); else passes++;
            checks++; if (dut.beats_left_r !== 5'd3) $display("FAIL wait_beats[%0d] got %0d exp 3", i, dut.beats_left_r); else passes++;
        end
        ready = 1'b1;
        tick();
        checks++; if (grant !== 4'b0100) $display("FAIL wait_beat2 got %b exp 0100", grant); else passes++;
        tick();
        checks++; if (grant !== 4'b0010 || master !== 2'd2)
            $display("FAIL wait_beat3 got %b/%0d exp 0010/2", grant, master); else passes++;
        busreq = 4'b0010;
        tick();
        checks++; if (master !== 2'd1) $display("FAIL wait_beat4_master got %0d exp 1", master); else passes++;
        trans = IDLE;
        tick();
    endtask

    task automatic test_lock();
        drive(1'b1, 4'b0000, 4'b0000, IDLE, 3'b000, 1'b1);
        tick();
        drive(1'b0, 4'b1000, 4'b1000, IDLE, 3'b000, 1'b1);
        tick();
        checks++; if (grant !== 4'b1000) $display("FAIL lock_grant got %b exp 1000", grant); else passes++;
        tick();
        checks++; if (mastlock !== 1'b1 || master !== 2'd3)
            $display("FAIL lock_owner got %b/%0d exp 1/3", mastlock, master); else passes++;
        busreq = 4'b1111;
        for (int b = 0; b < 2; b++) begin
            for (int k = 0; k < 8; k++) begin
                trans = (k == 0) ? NONSEQ : SEQ;
                burst = 3'b101;
                tick();
                checks++; if (grant !== 4'b1000 || mastlock !== 1'b1)
                    $display("FAIL lock_hold[%0d.%0d] got %b/%b exp 1000/1", b, k, grant, mastlock); else passes++;
            end
        end
        lock = 4'b0000; trans = IDLE;
        tick();
        checks++; if (grant !== 4'b0001) $display("FAIL unlock_grant got %b exp 0001", grant); else passes++;
        tick();
        checks++; if (mastlock !== 1'b0 || master !== 2'd0)
            $display("FAIL unlock_owner got %b/%0d exp 0/0", mastlock, master); else passes++;
    endtask

    task automatic test_park_undef();
        drive(1'b1, 4'b0000, 4'b0000, IDLE, 3'b000, 1'b1);
        tick();
        drive(1'b0, 4'b0000, 4'b0000, IDLE, 3'b000, 1'b1);
        tick();
        checks++; if (grant !== 4'b0001) $display("FAIL park_grant got %b exp 0001", grant); else passes++;
        busreq = 4'b0010;
        tick();
        checks++; if (grant !== 4'b0010) $display("FAIL park_req1 got %b exp 0010", grant); else passes++;
        tick();
        trans = NONSEQ; burst = 3'b001;
        tick();
        checks++; if (grant !== 4'b0010) $display("FAIL incr_nonseq got %b exp 0010", grant); else passes++;
        trans = SEQ;
        tick();
        checks++; if (grant !== 4'b0010) $display("FAIL incr_seq got %b exp 0010", grant); else passes++;
        busreq = 4'b0000;
        tick();
        checks++; if (grant !== 4'b0001) $display("FAIL incr_drop got %b exp 0001", grant); else passes++;
        drive(1'b0, 4'b0010, 4'b0000, IDLE, 3'b000, 1'b1);
        tick(); tick();
        drive(1'b0, 4'b0010, 4'b0000, NONSEQ, 3'b101, 1'b1);
        tick();
        trans = SEQ;
        tick();
        checks++; if (dut.beats_left_r !== 5'd6) $display("FAIL midburst_beats got %0d exp 6", dut.beats_left_r); else passes++;
        rst = 1'b1;
        tick();
        checks++; if (grant !== 4'b0001 || master !== 2'd0 || mastlock !== 1'b0)
            $display("FAIL midburst_reset got %b/%0d/%b exp 0001/0/0", grant, master, mastlock); else passes++;
        checks++; if (dut.beats_left_r !== 5'd0) $display("FAIL midburst_reset_beats got %0d exp 0", dut.beats_left_r); else passes++;
    endtask

    task automatic test_random();
        drive(1'b1, 4'b0000, 4'b0000, IDLE, 3'b000, 1'b1);
        tick();
        for (int c = 0; c < 3000; c++) begin
            rst    = (($urandom % 64) == 0);
            busreq = 4'($urandom);
            lock   = (($urandom % 4) == 0) ? 4'($urandom) : 4'b0000;
            trans  = 2'($urandom);
            burst  = 3'($urandom);
            ready  = (($urandom % 4) != 0);
            tick();
            checks++; if (grant !== 4'(1 << m_owner))
                $display("FAIL rand_grant[%0d] got %b exp %b", c, grant, 4'(1 << m_owner)); else passes++;
            checks++; if (master !== 2'(m_master))
                $display("FAIL rand_master[%0d] got %0d exp %0d", c, master, m_master); else passes++;
            checks++; if (mastlock !== m_mlock)
                $display("FAIL rand_mastlock[%0d] got %b exp %b", c, mastlock, m_mlock); else passes++;
            checks++; if (dut.beats_left_r !== 5'(m_beats))
                $display("FAIL rand_beats[%0d] got %0d exp %0d", c, dut.beats_left_r, m_beats); else passes++;
        end
    endtask

    initial begin
        drive(1'b1, 4'b0000, 4'b0000, IDLE, 3'b000, 1'b1);
        test_reset();
        test_round_robin();
        test_incr4();
        test_wait_states();
        test_lock();
        test_park_undef();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
